// File: rtl/ysyx_25020042_pkg.sv
// ysyx_25020042_pkg: shared funct3 codes, LSU state encoding, default width and funct3 legality helper
package ysyx_25020042_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;
  function automatic logic f3_bad(input logic ld, input logic st, input logic [2:0] f3);
    return ld ? (f3 == 3'b011 || f3[2:1] == 2'b11) : st ? (f3 > F3_SW) : 1'b0;
  endfunction
endpackage

// File: rtl/ysyx_25020042_lsu_align.sv
// ysyx_25020042_lsu_align: load lane select/extension and store byte-lane mask/data generation
module ysyx_25020042_lsu_align
  import ysyx_25020042_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] ld_data,
  output logic [3:0]       st_mask,
  output logic [WIDTH-1:0] st_data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[8*off +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  assign ld_data = funct3 == F3_LB  ? {{(WIDTH-8){b[7]}}, b} :
                   funct3 == F3_LH  ? {{(WIDTH-16){h[15]}}, h} :
                   funct3 == F3_LBU ? {{(WIDTH-8){1'b0}}, b} :
                   funct3 == F3_LHU ? {{(WIDTH-16){1'b0}}, h} : rdata;
  assign st_mask = funct3 == F3_SB ? 4'b0001 << off :
                   funct3 == F3_SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = funct3 == F3_SB ? {4{wdata[7:0]}} :
                   funct3 == F3_SH ? {2{wdata[15:0]}} : wdata;
endmodule

// File: rtl/ysyx_25020042_lsu.sv
// ysyx_25020042_lsu: 4-state load/store FSM (decode in, word-aligned mem req/rsp, result out); YSYX_25020042_LSU_MISALIGN_CHK_EN enables misalign faults
module ysyx_25020042_lsu
  import ysyx_25020042_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata,
  output logic             out_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_wen,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wmask,
  input  logic             mem_rsp_valid,
  output logic             mem_rsp_ready,
  input  logic [WIDTH-1:0] mem_rsp_rdata,
  input  logic             mem_rsp_err
);
  state_e state_q, state_d;
  logic load_q, load_d, store_q, store_d, err_q, err_d, bad;
  logic [2:0] f3_q, f3_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ld_data, st_data;
  logic [3:0] st_mask;
  ysyx_25020042_lsu_align #(.WIDTH(WIDTH)) u_align (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .rdata  (mem_rsp_rdata),
    .ld_data(ld_data),
    .st_mask(st_mask),
    .st_data(st_data)
  );
`ifdef YSYX_25020042_LSU_MISALIGN_CHK_EN
  assign bad = f3_bad(in_is_load, in_is_store, in_funct3) | ((in_is_load | in_is_store) &
               ((in_funct3[1:0] == 2'b01 && in_addr[0]) || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00)));
`else
  assign bad = f3_bad(in_is_load, in_is_store, in_funct3);
`endif
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        load_d  = in_is_load;
        store_d = in_is_store;
        f3_d    = in_funct3;
        addr_d  = in_addr;
        wdata_d = in_wdata;
        rdata_d = '0;
        err_d   = bad;
        state_d = ((in_is_load | in_is_store) && !bad) ? S_REQ : S_RESP;
      end
      S_REQ:  state_d = mem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: if (mem_rsp_valid) begin
        rdata_d = (load_q && !mem_rsp_err) ? ld_data : '0;
        err_d   = mem_rsp_err;
        state_d = S_RESP;
      end
      S_RESP: state_d = out_ready ? S_IDLE : S_RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign in_ready      = !rst && state_q == S_IDLE;
  assign mem_req_valid = !rst && state_q == S_REQ;
  assign mem_rsp_ready = !rst && state_q == S_WAIT;
  assign out_valid     = !rst && state_q == S_RESP;
  assign out_rdata     = rst ? '0 : rdata_q;
  assign out_err       = !rst && err_q;
  assign mem_req_wen   = store_q;
  assign mem_req_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_req_wdata = st_data;
  assign mem_req_wmask = store_q ? st_mask : 4'b0000;
endmodule

// File: doc/ysyx_25020042_lsu.md
Name: ysyx_25020042_lsu

Overview:
- Load/store unit that sits directly upstream of the ALU; its load result drives the ALU `ram_data` input.
- Accepts one memory operation per handshake from decode (address, store data, RV32 funct3 size code).
- Issues a single word-aligned request to data memory, waits for the response, then aligns and extends the data.
- Presents the result with a valid/ready handshake. Multi-cycle FSM; one transaction in flight.

Parameters:
- WIDTH, 32, data/address width (RV32 only; other values unsupported).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation offered by decode
- in_ready  output  1  LSU idle and able to accept
- in_is_load  input  1  operation is a load
- in_is_store  input  1  operation is a store (never both high with in_is_load)
- in_funct3  input  3  RV32 size/sign code
- in_addr  input  WIDTH  byte address
- in_wdata  input  WIDTH  store data, right-justified
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_rdata  output  WIDTH  aligned, extended load data (0 for stores, non-memory ops, errors)
- out_err  output  1  bad funct3, misaligned access (optional), or memory error
- mem_req_valid  output  1  memory request
- mem_req_ready  input  1  memory accepts request
- mem_req_wen  output  1  1 = write
- mem_req_addr  output  WIDTH  in_addr with bits [1:0] cleared
- mem_req_wdata  output  WIDTH  store data replicated into byte lanes
- mem_req_wmask  output  4  byte-lane write enables (0 for reads)
- mem_rsp_valid  input  1  memory response
- mem_rsp_ready  output  1  LSU accepts response
- mem_rsp_rdata  input  WIDTH  raw read word
- mem_rsp_err  input  1  bus error

Behaviour:
- Clocking and reset:
  - One clock `clk`. Reset `rst` is synchronous and active-high.
  - While `rst` is high: state=IDLE, all latched fields 0, in_ready=0, out_valid=0, mem_req_valid=0, mem_rsp_ready=0, out_rdata=0, out_err=0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch all in_* fields.
  - funct3 decode: illegal load codes are 011, 110, 111; illegal store codes are any value not in {000, 001, 010}.
  - Illegal code, or neither load nor store → RESP with out_err=illegal, rdata=0.
  - Otherwise → REQ.
- REQ:
  - mem_req_valid=1; all mem_req_* stable until mem_req_ready.
  - Transfer completes on mem_req_valid&mem_req_ready → WAIT.
- WAIT:
  - mem_rsp_ready=1.
  - On mem_rsp_valid: capture data and error → RESP.
  - mem_rsp_valid in the same cycle as the request handshake is not accepted; it is sampled from the next cycle.
- RESP:
  - out_valid=1; out_rdata and out_err held stable until out_ready.
  - On out_valid&out_ready → IDLE. No new accept in the same cycle; back-to-back issue is one op per 4 cycles minimum.
- Latency: accept at cycle 0, request at cycle 1, earliest response at cycle 2, out_valid at cycle 3.
- Loads:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - mem_rsp_err=1 forces out_rdata=0 and out_err=1.
- Stores:
  - SB: wmask = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011<<(2*addr[1]), wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111.
  - out_rdata=0 for all stores.
- Reset mid-transaction:
  - Transaction is abandoned; next cycle is IDLE with no output pulse.
  - The memory side is reset by the same `rst` and must drop any pending response.
- mem_rsp_valid while not in WAIT is ignored (mem_rsp_ready=0).

Optional Feature:
- Macro: YSYX_25020042_LSU_MISALIGN_CHK_EN.
- Defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0.
  - They go IDLE→RESP with out_err=1 and no memory request.
- Undefined:
  - No misalignment check.
  - Halfword ops ignore addr[0]; word ops ignore addr[1:0].

Decomposition:
- Package ysyx_25020042_pkg:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - LSU state encoding localparams.
  - WIDTH default.
- Sub-module ysyx_25020042_lsu_align, purely combinational:
  - Load lane select and extension.
  - Store wmask/wdata lane generation.
- The FSM and handshakes stay in the top module.

Test Plan:
- LB at addr 0x80000003, rsp word 0x80112233, immediate ready → out_valid at cycle 3, out_rdata=0xFFFFFF80, out_err=0.
- LHU at addr 0x80000002, rsp 0xBEEF1234 → out_rdata=0x0000BEEF. LH at the same address → 0xFFFFBEEF.
- SB at addr 0x80000001, wdata 0x000000A5 → mem_req_addr=0x80000000, wmask=0010, wdata=0xA5A5A5A5, wen=1; then out_valid with rdata=0.
- Stall handling: mem_req_ready low 3 cycles, mem_rsp_valid delayed 2 cycles, out_ready low 2 cycles → req fields stable, single request, out_rdata stable, in_ready=0 throughout.
- Error paths:
  - funct3=011 load → no mem_req_valid, out_err=1.
  - mem_rsp_err=1 on LW → out_err=1, rdata=0.
  - With the macro defined, LW at 0x80000002 → out_err=1 and no request.
  - Without the macro, the same LW → request to 0x80000000, out_err=0.
- rst asserted while in WAIT → next cycle IDLE, out_valid=0, mem_req_valid=0; a following LW completes normally.
